mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-port arbiter and sequencer in front of MEMORY (IROM 0..4K-1, DRAM 4K..8K-1).
//  Shares MEMORY's single port between instruction fetch (IF) and data load/store (D).
//  Uses round-robin priority, allows one read in flight, and tracks read latency.
//  Blocks stores outside the DRAM window and reports them on d_err_o.
// PARAMETERS
//  RD_LATENCY  1      cycles from the grant edge to memrdata_i valid (>=1)
//  DRAM_BASE   4096   first writable address
//  DRAM_LIMIT  8192   first address above the writable window
// PORTS
//  clk          in   1            clock, all state updates on the rising edge
//  rst          in   1            asynchronous, active-low reset
//  if_req_i     in   1            fetch request; held high with a stable address until if_gnt_o
//  if_addr_i    in   ADDR_WIDTH   fetch address
//  if_gnt_o     out  1            fetch request accepted this cycle (combinational)
//  if_rvalid_o  out  1            if_rdata_o valid this cycle (1-cycle pulse)
//  if_rdata_o   out  WIDTH        fetch read data
//  d_req_i      in   1            data request; held high with stable we/addr/wdata until d_gnt_o
//  d_we_i       in   1            1 = store, 0 = load
//  d_addr_i     in   ADDR_WIDTH   data address
//  d_wdata_i    in   WIDTH        store data
//  d_gnt_o      out  1            data request accepted this cycle (combinational)
//  d_rvalid_o   out  1            load data valid this cycle (1-cycle pulse)
//  d_rdata_o    out  WIDTH        load data
//  d_err_o      out  1            1-cycle pulse the cycle after a granted out-of-window store
//  memread_o    out  1            to MEMORY memread_i
//  memwrite_o   out  1            to MEMORY memwrite_i
//  memaddr_o    out  ADDR_WIDTH   to MEMORY memaddr_i
//  memwdata_o   out  WIDTH        to MEMORY memwdata_i
//  memrdata_i   in   WIDTH        from MEMORY memrdata_o
// BEHAVIOUR
//  - Reset (rst=0): state=IDLE, cnt=0, prio=D, owner=D, err_q=0.
//    All *_gnt_o, *_rvalid_o, d_err_o, memread_o and memwrite_o are 0, with or without a pending request.
//    memaddr_o, memwdata_o and rdata outputs are 0 during reset.
//  - FSM IDLE: may grant when a request is present.
//  - FSM RDWAIT: a read is in flight; cnt counts down from RD_LATENCY.
//  - Grant is allowed in IDLE, or in RDWAIT on the cycle cnt==1 (back-to-back reads).
//  - Winner selection: with one requester, it wins. With both, the requester named by prio wins.
//  - After every grant, prio := the non-granted port.
//  - Grant cycle: winner's gnt_o=1.
//    memaddr_o/memwdata_o are driven combinationally from the winner.
//    memread_o = ~we; memwrite_o = we & in_window.
//  - in_window = (addr >= DRAM_BASE) && (addr < DRAM_LIMIT).
//  - Read grant: owner := winner, cnt := RD_LATENCY, state := RDWAIT.
//    RD_LATENCY cycles later: owner's rvalid_o=1 and rdata_o = memrdata_i (combinational passthrough).
//    The other port's rdata_o is 0 in that cycle.
//  - Store grant: no rvalid. State stays IDLE, unless it returns from RDWAIT on cnt==1, in which case it goes to IDLE.
//    Out-of-window store: memwrite_o=0, d_gnt_o still 1, d_err_o=1 in the next cycle.
//  - Fetch reads are never range-checked; loads may target IROM or DRAM.
//  - No grant while RDWAIT and cnt>1; requests stay pending, no gnt.
//  - cnt==1 with no new read granted: state -> IDLE.
//  - Reset asserted mid-read: the in-flight read is dropped; no rvalid after reset is released. Requesters must reissue.
//  - Request dropped before grant: no grant and no memory access; prio is unchanged.
// TESTING
//  1. Reset held low with if_req_i=d_req_i=1 -> all gnt/rvalid/memread/memwrite 0.
//     Release -> d_gnt_o=1 first (prio=D).
//  2. IF only, addr 0x10, RD_LATENCY=1 -> if_gnt_o cycle T.
//     if_rvalid_o cycle T+1 with IROM[0x10]; new fetch granted in T+1.
//  3. Both requesting continuously, all loads -> grants alternate D,IF,D,IF.
//     rvalid lands on the matching port each time.
//  4. Store addr 4100, data 0xA5A5 -> memwrite_o=1 in grant cycle.
//     A later load of 4100 returns 0xA5A5; d_err_o stays 0.
//  5. Store addr 100 and store addr 8192 -> memwrite_o=0, d_gnt_o=1.
//     d_err_o pulses for 1 cycle after each store; IROM contents unchanged.
//  6. RD_LATENCY=3: load granted, then rst=0 at T+1 -> no d_rvalid_o ever.
//     After release, state IDLE and the pending IF is granted in the first cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between instruction fetch and data access.
// Tracks one read in flight and suppresses stores that fall outside the DRAM window.
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int WIDTH      = 32,
  parameter int RD_LATENCY = 1,
  parameter int DRAM_BASE  = 4096,
  parameter int DRAM_LIMIT = 8192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [WIDTH-1:0]      if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [WIDTH-1:0]      d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [WIDTH-1:0]      d_rdata_o,
  output logic                  d_err_o,
  output logic                  memread_o,
  output logic                  memwrite_o,
  output logic [ADDR_WIDTH-1:0] memaddr_o,
  output logic [WIDTH-1:0]      memwdata_o,
  input  logic [WIDTH-1:0]      memrdata_i
);

  localparam int CW = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LATENCY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(DRAM_BASE);
  localparam logic [ADDR_WIDTH-1:0] LIMIT_A = ADDR_WIDTH'(DRAM_LIMIT);
  localparam logic PORT_D  = 1'b0;
  localparam logic PORT_IF = 1'b1;

  typedef enum logic [0:0] {IDLE = 1'b0, RDWAIT = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            prio;
  logic            owner;
  logic            err_q;

  logic                  last_cycle;
  logic                  can_grant;
  logic                  d_win;
  logic                  if_win;
  logic                  grant;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic                  in_window;
  logic                  rd_done;

  // The final wait cycle of a read doubles as a grant slot so reads can stream back-to-back.
  assign last_cycle = (state == RDWAIT) && (cnt == CNT_ONE);
  assign can_grant  = rst && ((state == IDLE) || last_cycle);
  assign d_win      = d_req_i && (!if_req_i || (prio == PORT_D));
  assign if_win     = if_req_i && (!d_req_i || (prio == PORT_IF));
  assign grant      = can_grant && (d_req_i || if_req_i);
  assign win_we     = d_win && d_we_i;
  assign win_addr   = d_win ? d_addr_i : if_addr_i;
  assign in_window  = (win_addr >= BASE_A) && (win_addr < LIMIT_A);
  assign rd_done    = rst && last_cycle;

  assign d_gnt_o     = grant && d_win;
  assign if_gnt_o    = grant && if_win;
  assign memread_o   = grant && !win_we;
  assign memwrite_o  = grant && win_we && in_window;
  assign memaddr_o   = grant ? win_addr : '0;
  assign memwdata_o  = (grant && d_win) ? d_wdata_i : '0;

  assign if_rvalid_o = rd_done && (owner == PORT_IF);
  assign d_rvalid_o  = rd_done && (owner == PORT_D);
  assign if_rdata_o  = if_rvalid_o ? memrdata_i : '0;
  assign d_rdata_o   = d_rvalid_o ? memrdata_i : '0;
  assign d_err_o     = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      prio  <= PORT_D;
      owner <= PORT_D;
      err_q <= 1'b0;
    end else begin
      err_q <= grant && win_we && !in_window;
      if (grant) begin
        prio <= d_win ? PORT_IF : PORT_D;
      end
      if (grant && !win_we) begin
        state <= RDWAIT;
        cnt   <= CNT_LOAD;
        owner <= d_win ? PORT_D : PORT_IF;
      end else if (state == RDWAIT) begin
        if (cnt == CNT_ONE) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CNT_ONE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a transaction-level reference model.
`default_nettype none

module tb_mem_arbiter;

  localparam int AW   = 16;
  localparam int W    = 32;
  localparam int LAT  = 1;
  localparam int MEMN = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT with single-cycle read latency ----------------
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [W-1:0]  if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [W-1:0]  d_wdata, d_rdata;
  logic          memread, memwrite;
  logic [AW-1:0] memaddr;
  logic [W-1:0]  memwdata, memrdata;

  mem_arbiter #(.ADDR_WIDTH(AW), .WIDTH(W), .RD_LATENCY(LAT), .DRAM_BASE(4096), .DRAM_LIMIT(8192)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .memread_o(memread), .memwrite_o(memwrite), .memaddr_o(memaddr), .memwdata_o(memwdata),
    .memrdata_i(memrdata)
  );

  // ---------------- DUT with three-cycle read latency ----------------
  logic          rst3;
  logic          if_req3, if_gnt3, if_rvalid3;
  logic [AW-1:0] if_addr3;
  logic [W-1:0]  if_rdata3;
  logic          d_req3, d_we3, d_gnt3, d_rvalid3, d_err3;
  logic [AW-1:0] d_addr3;
  logic [W-1:0]  d_wdata3, d_rdata3;
  logic          memread3, memwrite3;
  logic [AW-1:0] memaddr3;
  logic [W-1:0]  memwdata3;
  logic [W-1:0]  memrdata3 = 32'hC0FFEE00;

  mem_arbiter #(.ADDR_WIDTH(AW), .WIDTH(W), .RD_LATENCY(3), .DRAM_BASE(4096), .DRAM_LIMIT(8192)) u_dut3 (
    .clk(clk), .rst(rst3),
    .if_req_i(if_req3), .if_addr_i(if_addr3), .if_gnt_o(if_gnt3), .if_rvalid_o(if_rvalid3), .if_rdata_o(if_rdata3),
    .d_req_i(d_req3), .d_we_i(d_we3), .d_addr_i(d_addr3), .d_wdata_i(d_wdata3),
    .d_gnt_o(d_gnt3), .d_rvalid_o(d_rvalid3), .d_rdata_o(d_rdata3), .d_err_o(d_err3),
    .memread_o(memread3), .memwrite_o(memwrite3), .memaddr_o(memaddr3), .memwdata_o(memwdata3),
    .memrdata_i(memrdata3)
  );

  // ---------------- memory device and reference contents ----------------
  function automatic logic [W-1:0] init_val(int a);
    logic [31:0] t;
    t = a;
    return (t * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  logic [W-1:0] dev_wr [int];
  logic [W-1:0] mdl_wr [int];
  logic [W-1:0] rd_q = '0;
  assign memrdata = rd_q;

  always @(posedge clk) begin
    if (memread && memaddr < MEMN)
      rd_q <= dev_wr.exists(int'(memaddr)) ? dev_wr[int'(memaddr)] : init_val(int'(memaddr));
    if (memwrite && memaddr < MEMN)
      dev_wr[int'(memaddr)] = memwdata;
  end

  function automatic logic [W-1:0] mdl_rd(int a);
    return mdl_wr.exists(a) ? mdl_wr[a] : init_val(a);
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // ---------------- stimulus queues and driver ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } ditem_t;

  typedef struct {
    int           due;
    logic [W-1:0] data;
  } exp_t;

  logic [AW-1:0] if_todo[$];
  ditem_t        d_todo[$];
  exp_t          q_if[$];
  exp_t          q_d[$];
  int            q_err[$];

  bit   chk_on   = 1'b0;
  bit   rnd_gaps = 1'b0;
  bit   ifg_s    = 1'b0;
  bit   dg_s     = 1'b0;

  // Requesters hold until the grant seen last cycle, then may present the next queued item.
  always @(posedge clk) begin
    ditem_t it;
    #1;
    if (if_req && ifg_s) if_req = 1'b0;
    if (d_req && dg_s)   d_req  = 1'b0;
    if (!if_req && if_todo.size() > 0 && (!rnd_gaps || $urandom_range(3) != 0)) begin
      if_addr = if_todo.pop_front();
      if_req  = 1'b1;
    end
    if (!d_req && d_todo.size() > 0 && (!rnd_gaps || $urandom_range(3) != 0)) begin
      it      = d_todo.pop_front();
      d_we    = it.we;
      d_addr  = it.addr;
      d_wdata = it.data;
      d_req   = 1'b1;
    end
  end

  // ---------------- predictor: arbitration from first principles ----------------
  int   free_cyc = 0;
  logic m_prio   = 1'b0;   // 0: data port has priority, 1: fetch port
  bit   p_gd, p_gif, p_inwin;
  int   p_addr;
  exp_t p_e;

  always @(negedge clk) begin
    ifg_s = if_gnt;
    dg_s  = d_gnt;
    if (chk_on) begin
      p_gd  = (cyc >= free_cyc) && d_req && (!if_req || m_prio == 1'b0);
      p_gif = (cyc >= free_cyc) && if_req && (!d_req || m_prio == 1'b1);
      chk("d_gnt", d_gnt, p_gd);
      chk("if_gnt", if_gnt, p_gif);
      if (p_gd || p_gif) begin
        m_prio = p_gd;
        if (p_gd && d_we) begin
          p_inwin = (d_addr >= 4096) && (d_addr < 8192);
          chk("store_memread", memread, 0);
          chk("store_memwrite", memwrite, p_inwin);
          chk("store_memaddr", memaddr, d_addr);
          if (p_inwin) begin
            chk("store_memwdata", memwdata, d_wdata);
            mdl_wr[int'(d_addr)] = d_wdata;
          end else begin
            q_err.push_back(cyc + 1);
          end
        end else begin
          p_addr = p_gd ? int'(d_addr) : int'(if_addr);
          chk("read_memread", memread, 1);
          chk("read_memwrite", memwrite, 0);
          chk("read_memaddr", memaddr, p_addr);
          p_e.due  = cyc + LAT;
          p_e.data = mdl_rd(p_addr);
          if (p_gd) q_d.push_back(p_e);
          else      q_if.push_back(p_e);
          free_cyc = cyc + LAT;
        end
      end else begin
        chk("idle_memread", memread, 0);
        chk("idle_memwrite", memwrite, 0);
      end
    end
  end

  // ---------------- monitor: pops expectations when the DUT responds ----------------
  exp_t m_e;

  always @(negedge clk) begin
    if (chk_on) begin
      if (if_rvalid) begin
        if (q_if.size() == 0) flag("if_rvalid_spurious");
        else begin
          m_e = q_if.pop_front();
          chk("if_rvalid_cycle", cyc, m_e.due);
          chk("if_rdata", if_rdata, m_e.data);
          chk("d_rdata_while_if", d_rdata, 0);
        end
      end else if (q_if.size() > 0 && q_if[0].due <= cyc) begin
        flag("if_rvalid_missing");
        void'(q_if.pop_front());
      end
      if (d_rvalid) begin
        if (q_d.size() == 0) flag("d_rvalid_spurious");
        else begin
          m_e = q_d.pop_front();
          chk("d_rvalid_cycle", cyc, m_e.due);
          chk("d_rdata", d_rdata, m_e.data);
          chk("if_rdata_while_d", if_rdata, 0);
        end
      end else if (q_d.size() > 0 && q_d[0].due <= cyc) begin
        flag("d_rvalid_missing");
        void'(q_d.pop_front());
      end
      if (d_err) begin
        if (q_err.size() == 0) flag("d_err_spurious");
        else chk("d_err_cycle", cyc, q_err.pop_front());
      end else if (q_err.size() > 0 && q_err[0] <= cyc) begin
        flag("d_err_missing");
        void'(q_err.pop_front());
      end
    end
  end

  task automatic wait_idle(int limit);
    int n = 0;
    while ((if_todo.size() > 0 || d_todo.size() > 0 || if_req || d_req ||
            q_if.size() > 0 || q_d.size() > 0 || q_err.size() > 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) flag("idle_timeout");
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int r;
    ditem_t it;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    rst3 = 1'b0; if_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0;
    if_addr3 = '0; d_addr3 = '0; d_wdata3 = '0;

    // Reset held with both ports requesting
    if_todo.push_back(16'h0010);
    d_todo.push_back('{1'b0, 16'd5000, 32'd0});
    repeat (3) begin
      @(negedge clk);
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_d_gnt", d_gnt, 0);
      chk("rst_if_rvalid", if_rvalid, 0);
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_memread", memread, 0);
      chk("rst_memwrite", memwrite, 0);
      chk("rst_memaddr", memaddr, 0);
      chk("rst_d_err", d_err, 0);
    end
    chk("rst_reqs_pending", {if_req, d_req}, 2'b11);
    @(posedge clk); #2;
    rst = 1'b1; rst3 = 1'b1;
    chk_on = 1'b1;
    wait_idle(100);

    // Fetch-only stream
    if_todo.push_back(16'h0010); if_todo.push_back(16'h0014); if_todo.push_back(16'h0018);
    wait_idle(100);

    // Both ports loading continuously
    for (int i = 0; i < 4; i++) begin
      if_todo.push_back(AW'(16'h20 + 4 * i));
      d_todo.push_back('{1'b0, AW'(4096 + i), 32'd0});
    end
    wait_idle(100);

    // In-window store then read back
    d_todo.push_back('{1'b1, 16'd4100, 32'h0000A5A5});
    d_todo.push_back('{1'b0, 16'd4100, 32'd0});
    wait_idle(100);

    // Out-of-window stores, then IROM readback
    d_todo.push_back('{1'b1, 16'd100, 32'h12345678});
    d_todo.push_back('{1'b1, 16'd8192, 32'h87654321});
    d_todo.push_back('{1'b0, 16'd100, 32'd0});
    d_todo.push_back('{1'b0, 16'd0, 32'd0});
    wait_idle(100);

    // Randomized traffic
    rnd_gaps = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if_todo.push_back(AW'($urandom_range(0, MEMN - 1)));
      it.we   = 1'($urandom_range(0, 1));
      it.data = $urandom;
      r = int'($urandom_range(0, 9));
      if (!it.we)      it.addr = AW'($urandom_range(0, MEMN - 1));
      else if (r < 7)  it.addr = AW'($urandom_range(4096, 8191));
      else if (r < 9)  it.addr = AW'($urandom_range(0, 4095));
      else             it.addr = AW'($urandom_range(8192, 8300));
      d_todo.push_back(it);
    end
    wait_idle(6000);
    chk_on = 1'b0;

    // Reset during an in-flight three-cycle read
    @(posedge clk); #2;
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 16'd10;
    if_req3 = 1'b1; if_addr3 = 16'h0040;
    @(negedge clk);
    chk("t6_d_gnt", d_gnt3, 1);
    chk("t6_if_waits", if_gnt3, 0);
    @(posedge clk); #2;
    d_req3 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("t6_rst_no_gnt", if_gnt3, 0);
    chk("t6_rst_no_rvalid", d_rvalid3, 0);
    @(posedge clk); #2;
    rst3 = 1'b1;
    @(negedge clk);
    chk("t6_if_gnt_first", if_gnt3, 1);
    @(posedge clk); #2;
    if_req3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t6_no_d_rvalid", d_rvalid3, 0);
      chk("t6_if_rvalid", if_rvalid3, (k == 3));
      if (k == 3) chk("t6_if_rdata", if_rdata3, 32'hC0FFEE00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
